instr_fetch_mem: RTL and testbench
==================================

# instr_fetch_mem

Parametrised instruction memory with a fetch handshake for the single-cycle CPU core. It replaces the fixed 19-bit by 128-entry combinational instruction array with a synchronous memory, a programmable fetch latency (wait states) and a program-load write port for filling the memory at run time. Out-of-range fetches are detected and flagged. The block sits between the CPU's `PC`/`INSTRUCTION` pins and the program loader.

## Interface
Parameters:
- `INSTR_WIDTH`, default 19: instruction word width.
- `DEPTH`, default 128: number of instruction words.
- `PC_WIDTH`, default 32: width of the PC. The PC is a word index, not a byte address.
- `WAIT_STATES`, default 1: extra cycles per fetch, range 0..15.
- `NOP_WORD`, default 0: word returned on reset and on faulting fetches.

Ports (`AW = clog2(DEPTH)`):
- `CLK`  in  1  clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `PC`  in  `PC_WIDTH`  fetch address, sampled together with `READ`.
- `READ`  in  1  fetch request.
- `INSTRUCTION`  out  `INSTR_WIDTH`  fetched word, registered.
- `VALID`  out  1  one-cycle pulse: `INSTRUCTION` is updated this cycle.
- `BUSYWAIT`  out  1  high while a fetch is in progress.
- `FAULT`  out  1  sticky out-of-range flag.
- `LOAD_EN`  in  1  write enable for the program loader.
- `LOAD_ADDR`  in  `AW`  write address.
- `LOAD_DATA`  in  `INSTR_WIDTH`  write data.

## Operation
- FSM states:
  - IDLE: `BUSYWAIT=0`.
  - WAIT: `BUSYWAIT=1`, wait-state counter running.
- IDLE → WAIT on an edge with `READ=1`:
  - `PC` is latched; later changes to `PC` do not affect this fetch.
  - The counter is loaded with `WAIT_STATES`.
- WAIT:
  - Each edge decrements the counter.
  - On the edge where the counter is 0, the fetch completes: `INSTRUCTION` ← mem[latched PC], `VALID`=1 for one cycle, `BUSYWAIT`=0, and the FSM returns to IDLE.
- `READ` while in WAIT is ignored. There is no queue; the CPU must hold or re-assert `READ`.
- Back-to-back fetches: `READ=1` sampled on the completion edge is not accepted. A new request is accepted on the next edge in IDLE.
- Out of range, when the latched PC ≥ `DEPTH` (full-width compare, no wrap-around):
  - At completion, `INSTRUCTION`=`NOP_WORD` and `FAULT`←1.
  - `VALID` still pulses.
  - `FAULT` stays at 1 until `RESET`.
- Load port:
  - `LOAD_EN=1` writes mem[`LOAD_ADDR`] ← `LOAD_DATA` on the edge.
  - Loads are legal in any state.
- Read/write collision: when a fetch completes on the same edge as a load to the same address, the fetch returns the old data (read-before-write).
- `RESET`:
  - FSM → IDLE, `INSTRUCTION`=`NOP_WORD`, `VALID`=0, `BUSYWAIT`=0, `FAULT`=0, counter=0.
  - A fetch in progress is aborted with no `VALID` pulse.
  - Memory contents are preserved.
  - `LOAD_EN` is ignored during the reset cycle.
- Simultaneous `RESET` and `READ`: reset wins; the request is dropped.

## Timing
- Fetch latency is `WAIT_STATES`+1 edges from the edge that accepts `READ` to the edge that asserts `VALID`.
  - With `WAIT_STATES=0`: `BUSYWAIT` is high for 1 cycle and `VALID` rises 1 edge after acceptance.
- Sustained throughput is one fetch per `WAIT_STATES`+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.
- A write is visible to any fetch that completes on a later edge.

## Structure
- Shared package `instr_mem_pkg` holds:
  - FSM state enum (IDLE, WAIT).
  - Default constants: `INSTR_WIDTH`=19, `DEPTH`=128, `NOP_WORD`.
  - Counter width constant (4 bits).
- One sub-module, `instr_mem_array`: `DEPTH`×`INSTR_WIDTH` storage, one synchronous write port, one read port, read-before-write on collision.
- The FSM, counter, fault logic and output registers live in the top module.

## Test plan
- Reset then idle: assert `RESET` 1 cycle → `INSTRUCTION`=0, `BUSYWAIT`=0, `VALID`=0, `FAULT`=0.
- Load then fetch, `WAIT_STATES=1`: load addr 3 with 19'h4_0C02; `READ` with `PC`=3 → `BUSYWAIT` high for 2 cycles, `VALID` on the 2nd edge, `INSTRUCTION`=19'h4_0C02.
- Zero wait states: `WAIT_STATES=0`; fetch addrs 0..19 back-to-back → each `VALID` 1 edge after acceptance, data matches loaded words, `READ` on completion edges ignored.
- Out of range: `PC`=128 → `INSTRUCTION`=0, `VALID` pulses, `FAULT`=1 and stays set; a later valid fetch does not clear it.
- Collision: fetch addr 5 (old 19'h1_1111) completing on the same edge as a load of 19'h2_2222 to addr 5 → returns 19'h1_1111; next fetch of addr 5 returns 19'h2_2222.
- Reset mid-fetch: `WAIT_STATES=3`; assert `RESET` in the 2nd wait cycle → no `VALID`, `BUSYWAIT`=0 the next cycle, memory still holds the loaded data.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and default constants for the instruction fetch memory.
// Holds the fetch FSM states, default geometry and the wait-state counter width.
package instr_mem_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

    localparam int              DEF_INSTR_WIDTH = 19;
    localparam int              DEF_DEPTH       = 128;
    localparam logic [18:0]     DEF_NOP_WORD    = 19'h0_0000;
    localparam int              CNT_W           = 4;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous write port, one combinational read port.
// Latency: write lands on the clock edge; read is same-cycle (the caller registers it).
// Backpressure: none; a read sampled on a write edge sees the old word.
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [INSTR_WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]          rd_addr,
    output logic [INSTR_WIDTH-1:0] rd_dat
);

    // No reset: program contents survive RESET.
    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with a READ/BUSYWAIT/VALID fetch handshake and a program-load port.
// Latency: WAIT_STATES+1 edges from accepted READ to the VALID pulse; all outputs registered.
// Backpressure: BUSYWAIT high while a fetch runs; READ is ignored then and never queued.
module instr_fetch_mem
    import instr_mem_pkg::*;
#(
    parameter int                     INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int                     DEPTH       = DEF_DEPTH,
    parameter int                     PC_WIDTH    = 32,
    parameter int                     WAIT_STATES = 1,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = INSTR_WIDTH'(DEF_NOP_WORD),
    localparam int                    AW          = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [PC_WIDTH-1:0]    PC,
    input  logic                   READ,
    output logic [INSTR_WIDTH-1:0] INSTRUCTION,
    output logic                   VALID,
    output logic                   BUSYWAIT,
    output logic                   FAULT,
    input  logic                   LOAD_EN,
    input  logic [AW-1:0]          LOAD_ADDR,
    input  logic [INSTR_WIDTH-1:0] LOAD_DATA
);

    fetch_state_e           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   fault_q, fault_d;
    logic [INSTR_WIDTH-1:0] rd_dat;
    logic                   pc_oor;

    // Full-width compare so large PCs never alias onto a valid word.
    assign pc_oor = (pc_q >= PC_WIDTH'(DEPTH));

    instr_mem_array #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .DEPTH       (DEPTH),
        .AW          (AW)
    ) u_array (
        .clk     (CLK),
        .wr_en   (LOAD_EN && !RESET),
        .wr_addr (LOAD_ADDR),
        .wr_dat  (LOAD_DATA),
        .rd_addr (pc_q[AW-1:0]),
        .rd_dat  (rd_dat)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (READ) begin
                    state_d = S_WAIT;
                    pc_d    = PC;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    valid_d = 1'b1;
                    if (pc_oor) begin
                        instr_d = NOP_WORD;
                        fault_d = 1'b1;
                    end else begin
                        instr_d = rd_dat;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign INSTRUCTION = instr_q;
    assign VALID       = valid_q;
    assign BUSYWAIT    = (state_q == S_WAIT);
    assign FAULT       = fault_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: three instances (0, 1 and 3 wait states) share stimulus.
module tb_instr_fetch_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        read;
    logic        load_en;
    logic [6:0]  load_addr;
    logic [18:0] load_data;

    logic [18:0] instr0, instr1, instr3;
    logic        valid0, valid1, valid3;
    logic        busy0, busy1, busy3;
    logic        fault0, fault1, fault3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_mem #(.WAIT_STATES(0)) dut0 (
        .CLK(clk), .RESET(reset), .PC(pc), .READ(read),
        .INSTRUCTION(instr0), .VALID(valid0), .BUSYWAIT(busy0), .FAULT(fault0),
        .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data)
    );

    instr_fetch_mem #(.WAIT_STATES(1)) dut1 (
        .CLK(clk), .RESET(reset), .PC(pc), .READ(read),
        .INSTRUCTION(instr1), .VALID(valid1), .BUSYWAIT(busy1), .FAULT(fault1),
        .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data)
    );

    instr_fetch_mem #(.WAIT_STATES(3)) dut3 (
        .CLK(clk), .RESET(reset), .PC(pc), .READ(read),
        .INSTRUCTION(instr3), .VALID(valid3), .BUSYWAIT(busy3), .FAULT(fault3),
        .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data)
    );

    function automatic logic [18:0] word_of(input int i);
        return 19'(32'h5000 + i * 37);
    endfunction

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic load(input int addr, input logic [18:0] data);
        load_en   = 1'b1;
        load_addr = 7'(addr);
        load_data = data;
        step();
        load_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; read = 1'b0; load_en = 1'b0; pc = '0; load_addr = '0; load_data = '0;
        step();
        reset = 1'b0;
        checks++; if (instr1 !== 19'h0) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr1, 19'h0); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy1); end
        checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid1); end
        checks++; if (fault1 !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault1); end
        // Reset and READ together: reset wins, request dropped.
        reset = 1'b1; read = 1'b1; pc = 32'd3;
        step();
        reset = 1'b0; read = 1'b0;
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_read_busy got=%b exp=0", busy1); end
        step();
        checks++; if (valid1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL reset_read_dropped valid=%b busy=%b exp=0/0", valid1, busy1); end
    endtask

    task automatic test_load_fetch();
        load(3, 19'h4_0C02);
        pc = 32'd3; read = 1'b1;
        step();
        read = 1'b0; pc = 32'd7;
        checks++; if (busy1 !== 1'b1 || valid1 !== 1'b0) begin failures++; $display("FAIL lf_accept busy=%b valid=%b exp=1/0", busy1, valid1); end
        step();
        checks++; if (busy1 !== 1'b1 || valid1 !== 1'b0) begin failures++; $display("FAIL lf_wait busy=%b valid=%b exp=1/0", busy1, valid1); end
        step();
        checks++; if (valid1 !== 1'b1 || busy1 !== 1'b0) begin failures++; $display("FAIL lf_done valid=%b busy=%b exp=1/0", valid1, busy1); end
        checks++; if (instr1 !== 19'h4_0C02) begin failures++; $display("FAIL lf_data got=%h exp=%h", instr1, 19'h4_0C02); end
        step();
        checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL lf_valid_pulse got=%b exp=0", valid1); end
        repeat (4) step();
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 20; i++) load(i, word_of(i));
        read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pc = 32'(i);
            step();
            checks++; if (busy0 !== 1'b1 || valid0 !== 1'b0) begin failures++; $display("FAIL zw_accept i=%0d busy=%b valid=%b exp=1/0", i, busy0, valid0); end
            // READ stays high and PC changes: neither may touch the running fetch.
            pc = 32'(i + 100);
            step();
            checks++; if (valid0 !== 1'b1 || busy0 !== 1'b0 || instr0 !== word_of(i)) begin
                failures++; $display("FAIL zw_done i=%0d valid=%b busy=%b got=%h exp=1/0/%h", i, valid0, busy0, instr0, word_of(i));
            end
        end
        read = 1'b0;
        step();
        checks++; if (valid0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL zw_end valid=%b busy=%b exp=0/0", valid0, busy0); end
        repeat (6) step();
    endtask

    task automatic test_out_of_range();
        do_reset();
        pc = 32'd128; read = 1'b1;
        step();
        read = 1'b0; pc = 32'd3;
        step();
        checks++; if (valid0 !== 1'b1 || instr0 !== 19'h0 || fault0 !== 1'b1) begin failures++; $display("FAIL oor0 valid=%b got=%h fault=%b exp=1/0/1", valid0, instr0, fault0); end
        step();
        checks++; if (valid1 !== 1'b1 || instr1 !== 19'h0 || fault1 !== 1'b1) begin failures++; $display("FAIL oor1 valid=%b got=%h fault=%b exp=1/0/1", valid1, instr1, fault1); end
        repeat (3) step();
        checks++; if (fault1 !== 1'b1) begin failures++; $display("FAIL oor_sticky got=%b exp=1", fault1); end
        pc = 32'd5; read = 1'b1;
        step();
        read = 1'b0;
        step();
        step();
        checks++; if (valid1 !== 1'b1 || instr1 !== word_of(5)) begin failures++; $display("FAIL oor_next valid=%b got=%h exp=1/%h", valid1, instr1, word_of(5)); end
        checks++; if (fault1 !== 1'b1) begin failures++; $display("FAIL oor_not_cleared got=%b exp=1", fault1); end
        repeat (4) step();
        do_reset();
        checks++; if (fault0 !== 1'b0) begin failures++; $display("FAIL oor_reset_clear got=%b exp=0", fault0); end
        // High PC bit set: must not alias onto word 3.
        pc = 32'h8000_0003; read = 1'b1;
        step();
        read = 1'b0;
        step();
        checks++; if (valid0 !== 1'b1 || instr0 !== 19'h0 || fault0 !== 1'b1) begin failures++; $display("FAIL oor_wide valid=%b got=%h fault=%b exp=1/0/1", valid0, instr0, fault0); end
        repeat (6) step();
    endtask

    task automatic test_collision();
        load(5, 19'h1_1111);
        pc = 32'd5; read = 1'b1;
        step();
        read = 1'b0;
        step();
        load_en = 1'b1; load_addr = 7'd5; load_data = 19'h2_2222;
        step();
        load_en = 1'b0;
        checks++; if (valid1 !== 1'b1 || instr1 !== 19'h1_1111) begin failures++; $display("FAIL coll_old valid=%b got=%h exp=1/%h", valid1, instr1, 19'h1_1111); end
        repeat (4) step();
        pc = 32'd5; read = 1'b1;
        step();
        read = 1'b0;
        step();
        step();
        checks++; if (valid1 !== 1'b1 || instr1 !== 19'h2_2222) begin failures++; $display("FAIL coll_new valid=%b got=%h exp=1/%h", valid1, instr1, 19'h2_2222); end
        repeat (4) step();
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        load(9, 19'h3_3333);
        pc = 32'd9; read = 1'b1;
        step();
        read = 1'b0;
        step();
        checks++; if (busy3 !== 1'b1) begin failures++; $display("FAIL rmf_busy got=%b exp=1", busy3); end
        // Reset in the 2nd wait cycle, with a load that must be ignored.
        reset = 1'b1; load_en = 1'b1; load_addr = 7'd9; load_data = 19'h7_7777;
        step();
        reset = 1'b0; load_en = 1'b0;
        checks++; if (busy3 !== 1'b0 || valid3 !== 1'b0 || instr3 !== 19'h0) begin failures++; $display("FAIL rmf_abort busy=%b valid=%b got=%h exp=0/0/0", busy3, valid3, instr3); end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (valid3 !== 1'b0) begin failures++; $display("FAIL rmf_no_valid k=%0d got=%b exp=0", k, valid3); end
        end
        pc = 32'd9; read = 1'b1;
        step();
        read = 1'b0;
        repeat (3) step();
        checks++; if (valid3 !== 1'b0 || busy3 !== 1'b1) begin failures++; $display("FAIL rmf_lat3 valid=%b busy=%b exp=0/1", valid3, busy3); end
        step();
        checks++; if (valid3 !== 1'b1 || instr3 !== 19'h3_3333) begin failures++; $display("FAIL rmf_mem valid=%b got=%h exp=1/%h", valid3, instr3, 19'h3_3333); end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_zero_wait();
        test_out_of_range();
        test_collision();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
